hs32_fetch: RTL and testbench

Instruction fetch stage of the HS32 core, directly upstream of decode/execute. It issues 32-bit instruction reads through the memory arbiter, buffers returned words with their PCs in a small FIFO, and presents them to decode with a valid/ack handshake. It honours the `flush`/`newpc` redirect that execute raises on branches, writes to R15 and interrupts, discarding every stale word.

---
 rtl/hs32_fetch_pkg.sv | 20 ++
 rtl/hs32_ififo.sv | 63 ++++++
 rtl/hs32_fetch.sv | 118 +++++++++++
 tb/tb_hs32_fetch.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hs32_fetch_pkg.sv
// Shared HS32 fetch-stage constants: FSM encodings, instruction size and FIFO entry layout.
package hs32_fetch_pkg;

    localparam logic [1:0] FT_IDLE  = 2'd0;
    localparam logic [1:0] FT_REQ   = 2'd1;
    localparam logic [1:0] FT_DRAIN = 2'd2;

    localparam logic [31:0] INSN_BYTES = 32'd4;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } insn_entry_t;

    // Instruction addresses are word aligned; low address bits are dropped.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & ~32'd3;
    endfunction

endpackage

// File: rtl/hs32_ififo.sv
// Instruction FIFO of {word, pc} entries; clear wins over push and pop.
module hs32_ififo
    import hs32_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_clear,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  insn_entry_t                  i_data,
    output insn_entry_t                  o_head,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_empty,
    output logic                         o_full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    insn_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;

    logic w_do_pop;
    logic w_do_push;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // NOTE: storage is reset here so the head reads as zero out of reset; only viable for tiny DEPTH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_tail] <= i_data;
                r_tail        <= r_tail + 1'b1;
            end
            if (w_do_pop) r_head <= r_head + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_head];
    assign o_count = r_count;

endmodule

// File: rtl/hs32_fetch.sv
// HS32 instruction fetch: issues word reads, buffers them with their PCs, honours flush/newpc redirects.
module hs32_fetch
    import hs32_fetch_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic [31:0] newpc,
    output logic [31:0] addr,
    input  logic [31:0] dtrm,
    output logic        reqm,
    input  logic        rdym,
    output logic [31:0] instd,
    output logic [31:0] instpc,
    output logic        valid,
    input  logic        ack
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [1:0]   r_state;
    logic [31:0]  r_fpc;
    logic [31:0]  r_addr;
    logic         r_reqm;

    insn_entry_t      w_head;
    logic [CNT_W-1:0] w_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_xfer;
    logic             w_has_room;
    logic [31:0]      w_addr_inc;

    assign w_xfer      = r_reqm && rdym;
    assign w_pop       = !w_empty && ack && !flush;
    assign w_push      = (r_state == FT_REQ) && w_xfer && !flush;
    assign w_count_nxt = w_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_has_room  = (w_count_nxt < CNT_W'(DEPTH));
    assign w_addr_inc  = r_addr + INSN_BYTES;

    hs32_ififo #(.DEPTH(DEPTH)) u_ififo (
        .clk     (clk),
        .reset   (reset),
        .i_clear (flush),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  ('{word: dtrm, pc: r_addr}),
        .o_head  (w_head),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= FT_IDLE;
            r_fpc   <= RESET_PC;
            r_addr  <= RESET_PC;
            r_reqm  <= 1'b0;
        end else if (flush) begin
            r_fpc <= align_pc(newpc);
            if (r_state == FT_IDLE || w_xfer) begin
                r_state <= FT_IDLE;
                r_reqm  <= 1'b0;
            end else begin
                // An outstanding read cannot be cancelled; wait it out and drop the data.
                r_state <= FT_DRAIN;
            end
        end else begin
            case (r_state)
                FT_IDLE: begin
                    if (w_has_room) begin
                        r_state <= FT_REQ;
                        r_addr  <= r_fpc;
                        r_reqm  <= 1'b1;
                    end
                end
                FT_REQ: begin
                    if (w_xfer) begin
                        r_fpc <= w_addr_inc;
                        if (w_has_room) begin
                            r_addr <= w_addr_inc;
                        end else begin
                            r_state <= FT_IDLE;
                            r_reqm  <= 1'b0;
                        end
                    end
                end
                FT_DRAIN: begin
                    if (w_xfer) begin
                        r_state <= FT_IDLE;
                        r_reqm  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= FT_IDLE;
                    r_reqm  <= 1'b0;
                end
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset) !(w_push && w_full && !w_pop));

    assign addr   = r_addr;
    assign reqm   = r_reqm;
    assign instd  = w_head.word;
    assign instpc = w_head.pc;
    assign valid  = !w_empty;

endmodule

// File: tb/tb_hs32_fetch.sv
// Directed bench for hs32_fetch with a stream-level fetch model checked every cycle.
module tb_hs32_fetch;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset, flush, ack, rdym, poison;
    logic [31:0] newpc, addr, dtrm, instd, instpc;
    logic        reqm, valid;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: expected delivery stream plus next expected fetch address.
    logic [31:0] m_words[$];
    logic [31:0] m_pcs[$];
    logic [31:0] m_pc;
    bit          m_stale;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    assign dtrm = poison ? 32'hDEAD_BEEF : mem_word(addr);

    hs32_fetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk    (clk),
        .reset  (reset),
        .flush  (flush),
        .newpc  (newpc),
        .addr   (addr),
        .dtrm   (dtrm),
        .reqm   (reqm),
        .rdym   (rdym),
        .instd  (instd),
        .instpc (instpc),
        .valid  (valid),
        .ack    (ack)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Inputs change 1ns after posedge, so at negedge they hold the values the next edge samples.
    always @(negedge clk) begin
        if (!reset) begin
            check("m_rst_reqm", reqm, 0);
            check("m_rst_valid", valid, 0);
            m_words.delete();
            m_pcs.delete();
            m_pc    = RESET_PC;
            m_stale = 1'b0;
        end else begin
            check("m_valid", valid, m_words.size() > 0);
            if (m_words.size() > 0) begin
                check("m_instd", instd, m_words[0]);
                check("m_instpc", instpc, m_pcs[0]);
            end
            check("m_addr_align", addr[1:0], 0);
            check("m_no_poison", valid && instd == 32'hDEAD_BEEF, 0);
            if (flush) begin
                m_words.delete();
                m_pcs.delete();
                m_pc = newpc & ~32'd3;
                if (reqm && rdym) m_stale = 1'b0;
                else if (reqm)    m_stale = 1'b1;
            end else begin
                if (valid && ack && m_words.size() > 0) begin
                    void'(m_words.pop_front());
                    void'(m_pcs.pop_front());
                end
                if (reqm && rdym) begin
                    if (m_stale) begin
                        m_stale = 1'b0;
                    end else begin
                        check("m_fetch_addr", addr, m_pc);
                        m_words.push_back(dtrm);
                        m_pcs.push_back(m_pc);
                        m_pc = m_pc + 32'd4;
                    end
                end
            end
            check("m_depth", m_words.size() <= DEPTH, 1);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 100000ns");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; flush = 1'b0; ack = 1'b1; rdym = 1'b1; newpc = '0; poison = 1'b0;
        tick();
        tick();
        check("rst_addr", addr, RESET_PC);
        check("rst_reqm", reqm, 0);
        check("rst_valid", valid, 0);
        check("rst_instd", instd, 0);
        check("rst_instpc", instpc, 0);

        // Free run with zero-wait memory and decode acking every cycle.
        reset = 1'b1;
        tick();
        check("run_first_reqm", reqm, 1);
        check("run_first_addr", addr, 32'h0);
        check("run_first_valid", valid, 0);
        for (int k = 2; k < 8; k++) begin
            tick();
            check("run_addr", addr, 32'(4 * (k - 1)));
            check("run_valid", valid, 1);
            check("run_instpc", instpc, 32'(4 * (k - 2)));
        end

        // Backpressure: decode stalls, FIFO fills to two words.
        reset = 1'b0; ack = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        check("bp_reqm0", reqm, 1);
        tick();
        check("bp_addr1", addr, 32'h4);
        tick();
        check("bp_reqm_drop", reqm, 0);
        check("bp_head_pc", instpc, 32'h0);
        tick();
        tick();
        check("bp_hold_reqm", reqm, 0);
        check("bp_hold_pc", instpc, 32'h0);
        check("bp_hold_word", instd, 32'hC0DE_0000);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("bp_one_req", reqm, 1);
        check("bp_one_addr", addr, 32'h8);
        check("bp_new_head", instpc, 32'h4);
        tick();
        check("bp_req_done", reqm, 0);
        tick();
        check("bp_no_more_req", reqm, 0);
        check("bp_addr_hold", addr, 32'h8);

        // Flush while idle with a full FIFO; unaligned target.
        flush = 1'b1; newpc = 32'h0000_1003;
        tick();
        flush = 1'b0;
        check("fi_valid", valid, 0);
        check("fi_reqm", reqm, 0);
        tick();
        check("fi_reqm_up", reqm, 1);
        check("fi_addr", addr, 32'h0000_1000);
        check("fi_valid2", valid, 0);
        ack = 1'b1;
        tick();
        check("fi_first_valid", valid, 1);
        check("fi_first_pc", instpc, 32'h0000_1000);
        check("fi_first_word", instd, 32'hC0DE_1000);

        // Flush during a wait-stated read at 0x10.
        flush = 1'b1; newpc = 32'h10;
        tick();
        flush = 1'b0; rdym = 1'b0;
        check("fw_setup_reqm", reqm, 0);
        tick();
        check("fw_req10", reqm, 1);
        check("fw_addr10", addr, 32'h10);
        flush = 1'b1; newpc = 32'h200; poison = 1'b1;
        tick();
        flush = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("fw_drain_reqm", reqm, 1);
            check("fw_drain_addr", addr, 32'h10);
            check("fw_drain_valid", valid, 0);
            if (k < 2) tick();
        end
        rdym = 1'b1;
        tick();
        poison = 1'b0;
        check("fw_drop_reqm", reqm, 0);
        check("fw_drop_valid", valid, 0);
        tick();
        check("fw_resume_reqm", reqm, 1);
        check("fw_resume_addr", addr, 32'h200);
        tick();
        check("fw_resume_valid", valid, 1);
        check("fw_resume_pc", instpc, 32'h200);
        check("fw_resume_word", instd, 32'hC0DE_0200);

        // Flush, ack and rdym together; then wrap across 2^32.
        check("sim_pre_valid", valid, 1);
        flush = 1'b1; newpc = 32'h3000;
        tick();
        flush = 1'b0;
        check("sim_valid", valid, 0);
        check("sim_reqm", reqm, 0);
        tick();
        check("sim_addr", addr, 32'h3000);
        check("sim_reqm_up", reqm, 1);
        flush = 1'b1; newpc = 32'hFFFF_FFFC;
        tick();
        flush = 1'b0;
        check("wrap_reqm", reqm, 0);
        tick();
        check("wrap_addr_top", addr, 32'hFFFF_FFFC);
        tick();
        check("wrap_addr_zero", addr, 32'h0);
        check("wrap_pc", instpc, 32'hFFFF_FFFC);
        check("wrap_word", instd, 32'h3F21_FFFC);
        tick();
        check("wrap_addr4", addr, 32'h4);
        check("wrap_pc0", instpc, 32'h0);

        // Asynchronous reset between clock edges mid-REQ.
        check("ar_pre_reqm", reqm, 1);
        #2 reset = 1'b0;
        #1;
        check("ar_reqm", reqm, 0);
        check("ar_valid", valid, 0);
        check("ar_addr", addr, RESET_PC);
        tick();
        reset = 1'b1;
        tick();
        check("ar_restart_reqm", reqm, 1);
        check("ar_restart_addr", addr, RESET_PC);
        tick();
        check("ar_restart_valid", valid, 1);
        check("ar_restart_pc", instpc, RESET_PC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
